alu4_arbiter: RTL and testbench
===============================

# alu4_arbiter

Two-requester front end for the shared 4-bit ALU. Arbitrates between two independent command sources with valid/ready handshakes, drives the combinational `alu4` datapath with the winning operands, and captures the result in a one-entry output register tagged with the requester ID. It sits between the two command producers and a single result consumer, with full backpressure and one operation per cycle of throughput.

## Interface
- No parameters. Widths are fixed: 4-bit operands, 3-bit opcode.
- `clk  input  1  sole clock; all state updates on rising edge`
- `rst_n  input  1  asynchronous, active-low reset`
- `req0_valid  input  1  requester 0 has a command`
- `req0_ready  output  1  requester 0 command accepted this cycle when high with valid`
- `req0_a  input  4  operand A, requester 0`
- `req0_b  input  4  operand B, requester 0`
- `req0_sel  input  3  ALU opcode, requester 0`
- `req1_valid, req1_ready, req1_a, req1_b, req1_sel`: same as requester 0, for requester 1.
- `rsp_valid  output  1  result register holds a result`
- `rsp_ready  input  1  consumer takes the result this cycle`
- `rsp_out  output  4  ALU result`
- `rsp_carry  output  1  carry/borrow flag`
- `rsp_id  output  1  requester that issued the result`

## Operation
- Opcodes:
  - `000`: A+B.
  - `001`: A−B.
  - `010`: AND.
  - `011`: OR.
  - `100`: XOR.
  - `101`: A+1.
  - `110`: A−1.
  - `111`: clear to 0.
- Arithmetic wraps modulo 16.
- Carry rules:
  - `rsp_carry` is bit 4 of the 5-bit result for `000` and `001`. For `001`, carry=1 exactly when A<B (borrow).
  - For every other opcode, `rsp_carry` is forced to 0. The block masks it and never passes through a stale ALU carry.
- Slot free: `slot_free = !rsp_valid || rsp_ready`.
- Grant, combinational:
  - If only one request is valid, that requester is granted.
  - If both are valid, the winner is picked by the priority rule (see Configuration).
  - With no valid request, there is no grant.
- `reqN_ready = grantN && slot_free`. At most one ready is high per cycle. A non-granted requester sees ready=0.
- Accept occurs when `reqN_valid && reqN_ready` at a rising edge. The ALU result, masked carry and N load into the result register, and rsp_valid is set to 1.
- Register update when there is no accept:
  - If `rsp_valid && rsp_ready`, rsp_valid clears to 0.
  - Otherwise the register holds its value.
- Two-state control view:
  - EMPTY (rsp_valid=0): goes to FULL on an accept.
  - FULL (rsp_valid=1):
    - Goes to EMPTY on rsp_ready with no accept.
    - Stays FULL on rsp_ready with an accept (back-to-back).
    - Stays FULL on !rsp_ready. In this case ready=0 to both requesters, and the outputs stay stable.
- Requesters must hold their command stable while valid is high and ready is low. The arbiter does not latch unaccepted commands.
- The round-robin pointer `last_id` updates only on an accept, to the accepted ID.

## Timing
- Reset: rsp_valid=0, rsp_out=0, rsp_carry=0, rsp_id=0, last_id=1, req0_ready=0, req1_ready=0. With last_id=1, requester 0 wins the first tie.
- Reset assertion mid-operation clears the result register immediately, asynchronously. Any pending result is discarded, and no handshake completes in that cycle.
- Latency: a command accepted at edge N gives rsp_valid=1 with its result during cycle N+1.
- Throughput: one result per cycle while rsp_ready is held high.
- Response outputs are registered. Ready signals are combinational from valid inputs, last_id, rsp_valid and rsp_ready; there is no combinational path from operands to outputs.
- A simultaneous drain and accept in the same edge replaces the result without a bubble.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin.
  - On a tie, grant goes to the requester not equal to last_id.
  - A continuously requesting pair alternates 0,1,0,1.
- `ALU_ARB_RR_EN` undefined: fixed priority.
  - On a tie, requester 0 always wins; requester 1 is served only when req0_valid=0.
  - last_id is still maintained but has no effect.

## Test plan
- Reset, then req0 only with A=9, B=8, sel=000 and rsp_ready=1 → next cycle rsp_out=1, rsp_carry=1, rsp_id=0.
- req1 only with A=3, B=5, sel=001 → rsp_out=14, rsp_carry=1. Then A=5, B=3, sel=001 → rsp_out=2, rsp_carry=0. Then sel=011 after an add with carry → rsp_carry=0.
- Both requesters valid for 4 cycles, rsp_ready=1:
  - With `ALU_ARB_RR_EN` → rsp_id sequence 0,1,0,1.
  - Without it → 0,0,0,0, and req1_ready never asserts.
- Hold rsp_ready=0 for 3 cycles after one accept → both readys=0 and rsp_out/rsp_id unchanged. Raise rsp_ready → the held result drains, and the next command is accepted in the same edge.
- Assert rst_n=0 while rsp_valid=1 and rsp_ready=0 → rsp_valid=0 and outputs zero before the next clock edge. After release, the first tie goes to requester 0.
- Sweep all 8 opcodes on A=15, B=1 → rsp_out values:
  - sel `000`–`011`: 0, 14, 1, 15.
  - sel `100`–`111`: 14, 0, 14, 0.
  - rsp_carry=1 only for sel `000`.

Source files
------------

// File: rtl/alu4_arbiter_if.sv
// rtl/alu4_arbiter_if.sv - command/response handshake bundle between two requesters, the arbiter and the result consumer
interface alu4_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic [2:0] req0_sel;
  logic       req1_valid;
  logic       req1_ready;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic [2:0] req1_sel;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_out;
  logic       rsp_carry;
  logic       rsp_id;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_out, rsp_carry, rsp_id
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_out, rsp_carry, rsp_id
  );
endinterface

// File: rtl/alu4_arbiter.sv
// rtl/alu4_arbiter.sv - two-requester arbiter driving the 4-bit ALU into a one-entry tagged result register
// Define ALU_ARB_RR_EN for round-robin tie-break; otherwise requester 0 has fixed priority.
module alu4_arbiter (
  input  logic          clk,
  input  logic          rst_n,
  alu4_arbiter_if.slave bus
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] out_q, out_d;
  logic       carry_q, carry_d;
  logic       id_q, id_d;
  logic       last_q, last_d;

  logic       pick1_on_tie;
  logic       grant0, grant1;
  logic       slot_free;
  logic       acc0, acc1, accept;
  logic [3:0] op_a, op_b;
  logic [2:0] op_sel;
  logic [4:0] alu_wide;
  logic [3:0] alu_out;
  logic       alu_carry;

`ifdef ALU_ARB_RR_EN
  assign pick1_on_tie = ~last_q;
`else
  // last_id is tracked in both builds; only round-robin lets it steer ties
  assign pick1_on_tie = 1'b0 & ~last_q;
`endif

  assign grant1    = bus.req1_valid & (~bus.req0_valid | pick1_on_tie);
  assign grant0    = bus.req0_valid & ~grant1;
  assign slot_free = (state_q == S_EMPTY) | bus.rsp_ready;

  // Readys stay low while reset is held so no handshake can appear to complete
  assign bus.req0_ready = grant0 & slot_free & rst_n;
  assign bus.req1_ready = grant1 & slot_free & rst_n;

  assign acc0   = bus.req0_valid & bus.req0_ready;
  assign acc1   = bus.req1_valid & bus.req1_ready;
  assign accept = acc0 | acc1;

  assign op_a   = grant1 ? bus.req1_a   : bus.req0_a;
  assign op_b   = grant1 ? bus.req1_b   : bus.req0_b;
  assign op_sel = grant1 ? bus.req1_sel : bus.req0_sel;

  always_comb begin
    alu_wide = 5'd0;
    case (op_sel)
      3'b000:  alu_wide = {1'b0, op_a} + {1'b0, op_b};
      3'b001:  alu_wide = {1'b0, op_a} - {1'b0, op_b};
      3'b010:  alu_wide = {1'b0, op_a & op_b};
      3'b011:  alu_wide = {1'b0, op_a | op_b};
      3'b100:  alu_wide = {1'b0, op_a ^ op_b};
      3'b101:  alu_wide = {1'b0, op_a + 4'd1};
      3'b110:  alu_wide = {1'b0, op_a - 4'd1};
      default: alu_wide = 5'd0;
    endcase
    alu_out   = alu_wide[3:0];
    // Bit 4 is carry for add and borrow for subtract; everything else reports no carry
    alu_carry = ((op_sel == 3'b000) || (op_sel == 3'b001)) ? alu_wide[4] : 1'b0;
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    carry_d = carry_q;
    id_d    = id_q;
    last_d  = last_q;
    if (accept) begin
      state_d = S_FULL;
      out_d   = alu_out;
      carry_d = alu_carry;
      id_d    = acc1;
      last_d  = acc1;
    end else if ((state_q == S_FULL) && bus.rsp_ready) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      out_q   <= 4'd0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign bus.rsp_valid = (state_q == S_FULL);
  assign bus.rsp_out   = out_q;
  assign bus.rsp_carry = carry_q;
  assign bus.rsp_id    = id_q;

endmodule

// File: tb/tb_alu4_arbiter.sv
// tb/tb_alu4_arbiter.sv - directed and randomized bench for alu4_arbiter against a behavioural model
module tb_alu4_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu4_arbiter_if bus ();

  alu4_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef ALU_ARB_RR_EN
  localparam int RR = 1;
`else
  localparam int RR = 0;
`endif

  int checks = 0;
  int errors = 0;

  int m_valid, m_out, m_carry, m_id, m_last;
  int acc0_last, acc1_last;

  int sweep_out [8] = '{0, 14, 1, 15, 14, 0, 14, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void ref_alu(input int a, input int b, input int sel,
                                  output int r, output int c);
    c = 0;
    case (sel)
      0: begin r = (a + b) % 16; c = (a + b > 15) ? 1 : 0; end
      1: begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a + 1) % 16;
      6: r = (a + 15) % 16;
      default: r = 0;
    endcase
  endfunction

  function automatic int pick(input logic v0, input logic v1);
    if (v0 && v1) return (RR != 0) ? ((m_last == 1) ? 0 : 1) : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_out = 0; m_carry = 0; m_id = 0; m_last = 1;
    acc0_last = 0; acc1_last = 0;
  endtask

  task automatic drive(input int n, input bit v, input int a, input int b, input int sel);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_a = a[3:0]; bus.req0_b = b[3:0]; bus.req0_sel = sel[2:0];
    end else begin
      bus.req1_valid = v; bus.req1_a = a[3:0]; bus.req1_b = b[3:0]; bus.req1_sel = sel[2:0];
    end
  endtask

  task automatic cycle(input string tag);
    int w, free, e0, e1, wa, wb, ws, r, c;
    @(negedge clk);
    w    = pick(bus.req0_valid, bus.req1_valid);
    free = (m_valid == 0 || bus.rsp_ready) ? 1 : 0;
    e0   = (w == 0 && free == 1) ? 1 : 0;
    e1   = (w == 1 && free == 1) ? 1 : 0;
    wa   = (w == 1) ? int'(bus.req1_a)   : int'(bus.req0_a);
    wb   = (w == 1) ? int'(bus.req1_b)   : int'(bus.req0_b);
    ws   = (w == 1) ? int'(bus.req1_sel) : int'(bus.req0_sel);
    check({tag, ".rdy0"}, 32'(bus.req0_ready), e0);
    check({tag, ".rdy1"}, 32'(bus.req1_ready), e1);
    @(posedge clk);
    #1;
    if (e0 == 1 || e1 == 1) begin
      ref_alu(wa, wb, ws, r, c);
      m_valid = 1; m_out = r; m_carry = c; m_id = w; m_last = w;
    end else if (m_valid == 1 && bus.rsp_ready) begin
      m_valid = 0;
    end
    acc0_last = e0;
    acc1_last = e1;
    check({tag, ".valid"}, 32'(bus.rsp_valid), m_valid);
    check({tag, ".out"},   32'(bus.rsp_out),   m_out);
    check({tag, ".carry"}, 32'(bus.rsp_carry), m_carry);
    check({tag, ".id"},    32'(bus.rsp_id),    m_id);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", 32'(bus.rsp_valid), 0);
    check("rst.out",   32'(bus.rsp_out),   0);
    check("rst.carry", 32'(bus.rsp_carry), 0);
    check("rst.id",    32'(bus.rsp_id),    0);
    check("rst.rdy0",  32'(bus.req0_ready), 0);
    check("rst.rdy1",  32'(bus.req1_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    drive(0, 1, 9, 8, 0);
    cycle("add0");
    check("add0.exp_out",   32'(bus.rsp_out),   1);
    check("add0.exp_carry", 32'(bus.rsp_carry), 1);
    check("add0.exp_id",    32'(bus.rsp_id),    0);
    drive(0, 0, 0, 0, 0);

    drive(1, 1, 3, 5, 1);
    cycle("sub_borrow");
    check("sub_borrow.exp_out",   32'(bus.rsp_out),   14);
    check("sub_borrow.exp_carry", 32'(bus.rsp_carry), 1);
    check("sub_borrow.exp_id",    32'(bus.rsp_id),    1);
    drive(1, 1, 5, 3, 1);
    cycle("sub_plain");
    check("sub_plain.exp_out",   32'(bus.rsp_out),   2);
    check("sub_plain.exp_carry", 32'(bus.rsp_carry), 0);
    drive(1, 1, 9, 8, 0);
    cycle("add1");
    drive(1, 1, 9, 8, 3);
    cycle("or_after_carry");
    check("or_after_carry.exp_carry", 32'(bus.rsp_carry), 0);

    drive(0, 1, 1, 2, 0);
    drive(1, 1, 3, 4, 0);
    for (int i = 0; i < 4; i++) begin
      cycle("tie");
      check("tie.seq", 32'(bus.rsp_id), (RR != 0) ? (i % 2) : 0);
    end

    drive(1, 0, 0, 0, 0);
    drive(0, 1, 7, 2, 0);
    cycle("bp.load");
    check("bp.load.exp_out", 32'(bus.rsp_out), 9);
    bus.rsp_ready = 1'b0;
    drive(0, 1, 4, 4, 2);
    drive(1, 1, 6, 1, 4);
    for (int i = 0; i < 3; i++) begin
      cycle("bp.hold");
      check("bp.hold.out", 32'(bus.rsp_out), 9);
      check("bp.hold.id",  32'(bus.rsp_id),  0);
    end
    bus.rsp_ready = 1'b1;
    cycle("bp.drain");
    check("bp.drain.valid", 32'(bus.rsp_valid), 1);
    check("bp.drain.out",   32'(bus.rsp_out), (RR != 0) ? 7 : 4);

    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    cycle("pre_rst.drain");
    bus.rsp_ready = 1'b0;
    drive(1, 1, 2, 3, 0);
    cycle("pre_rst.load");
    drive(1, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid", 32'(bus.rsp_valid), 0);
    check("arst.out",   32'(bus.rsp_out),   0);
    check("arst.carry", 32'(bus.rsp_carry), 0);
    check("arst.id",    32'(bus.rsp_id),    0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    drive(0, 1, 1, 1, 0);
    drive(1, 1, 2, 2, 0);
    cycle("arst.tie");
    check("arst.tie.id", 32'(bus.rsp_id), 0);

    drive(1, 0, 0, 0, 0);
    for (int s = 0; s < 8; s++) begin
      drive(0, 1, 15, 1, s);
      cycle("sweep");
      check("sweep.out",   32'(bus.rsp_out),   sweep_out[s]);
      check("sweep.carry", 32'(bus.rsp_carry), (s == 0) ? 1 : 0);
    end

    for (int i = 0; i < 400; i++) begin
      if (!(bus.req0_valid && acc0_last == 0))
        drive(0, ($urandom_range(0, 9) < 6), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
      if (!(bus.req1_valid && acc1_last == 0))
        drive(1, ($urandom_range(0, 9) < 6), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
